// File: rtl/fetch_sequencer.sv
// Instruction-fetch controller: owns the PC, addresses the instruction ROM and
// presents each fetched word to decode through a one-entry valid/ready register.
module fetch_sequencer #(
    parameter int                ADDR_W      = 6,
    parameter logic [ADDR_W-1:0] RESET_PC    = '0,
    parameter logic [5:0]        HALT_OPCODE = 6'b111111
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        start_i,
    output logic [31:0] rom_addr_o,
    input  logic [31:0] rom_data_i,
    output logic [31:0] inst_o,
    output logic [31:0] pc_o,
    output logic        inst_valid_o,
    input  logic        inst_ready_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        halted_o
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_HALTED = 2'd2
    } state_t;

    state_t            state_q,   state_d;
    logic [ADDR_W-1:0] pc_q,      pc_d;
    logic [31:0]       inst_q,    inst_d;
    logic [ADDR_W-1:0] pc_out_q,  pc_out_d;
    logic              valid_q,   valid_d;
    logic              halted_q,  halted_d;

    logic              xfer;
    logic              is_halt;
    logic              can_load;
    logic              redirect_hi_unused;

    // Only the low ADDR_W bits of the redirect target address the ROM.
    assign redirect_hi_unused = ^redirect_pc_i[31:ADDR_W];

    assign xfer     = valid_q && inst_ready_i;
    assign is_halt  = (inst_q[31:26] == HALT_OPCODE);
    assign can_load = !valid_q || inst_ready_i;

    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q  <= ST_IDLE;
            pc_q     <= RESET_PC;
            inst_q   <= '0;
            pc_out_q <= '0;
            valid_q  <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            inst_q   <= inst_d;
            pc_out_q <= pc_out_d;
            valid_q  <= valid_d;
            halted_q <= halted_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        inst_d   = inst_q;
        pc_out_d = pc_out_q;
        valid_d  = valid_q;
        halted_d = halted_q;

        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d = ST_RUN;
                    pc_d    = RESET_PC;
                end
            end

            ST_RUN: begin
                // Redirect wins over everything, including a HALT being taken.
                if (redirect_i) begin
                    pc_d    = redirect_pc_i[ADDR_W-1:0];
                    valid_d = 1'b0;
                end else if (xfer && is_halt) begin
                    state_d  = ST_HALTED;
                    valid_d  = 1'b0;
                    halted_d = 1'b1;
                end else if (can_load) begin
                    inst_d   = rom_data_i;
                    pc_out_d = pc_q;
                    valid_d  = 1'b1;
                    pc_d     = pc_q + ADDR_W'(1);
                end
            end

            ST_HALTED: begin
                if (start_i) begin
                    state_d  = ST_RUN;
                    pc_d     = RESET_PC;
                    halted_d = 1'b0;
                end
            end

            default: begin
                state_d  = ST_IDLE;
                pc_d     = RESET_PC;
                valid_d  = 1'b0;
                halted_d = 1'b0;
            end
        endcase
    end

    assign rom_addr_o   = {{(32-ADDR_W){1'b0}}, pc_q};
    assign pc_o         = {{(32-ADDR_W){1'b0}}, pc_out_q};
    assign inst_o       = inst_q;
    assign inst_valid_o = valid_q;
    assign halted_o     = halted_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer: start, back-pressure, redirect, wrap,
// HALT, redirect-over-HALT and mid-run reset, against a behavioural ROM.
module tb_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic [31:0] inst;
    logic [31:0] pc_out;
    logic        valid;
    logic        ready;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        halted;

    logic [31:0] rom [0:63];

    int vectors = 0;
    int errors  = 0;

    fetch_sequencer dut (
        .clk_i        (clk),
        .rst_n_i      (rst_n),
        .start_i      (start),
        .rom_addr_o   (rom_addr),
        .rom_data_i   (rom_data),
        .inst_o       (inst),
        .pc_o         (pc_out),
        .inst_valid_o (valid),
        .inst_ready_i (ready),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .halted_o     (halted)
    );

    assign rom_data = rom[rom_addr[5:0]];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
            $display("chk %s ok %h", tag, obs);
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [31:0] i,
                           input logic [31:0] p, input logic h);
        chk({tag, ".valid"},  {31'd0, valid},  {31'd0, v});
        chk({tag, ".inst"},   inst,            i);
        chk({tag, ".pc"},     pc_out,          p);
        chk({tag, ".halted"}, {31'd0, halted}, {31'd0, h});
    endtask

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'hA000_0000 + i;
        rst_n = 1'b0; start = 1'b0; ready = 1'b0;
        redirect = 1'b0; redirect_pc = '0;

        // Reset state
        step(); step();
        chk_out("reset", 1'b0, 32'd0, 32'd0, 1'b0);
        chk("reset.addr", rom_addr, 32'd0);

        // Start: valid from the second edge after start
        rst_n = 1'b1;
        step();
        chk("idle.valid", {31'd0, valid}, 32'd0);
        start = 1'b1; ready = 1'b1;
        step();
        start = 1'b0;
        chk("start.e0.valid", {31'd0, valid}, 32'd0);
        chk("start.e0.addr", rom_addr, 32'd0);
        step();
        chk_out("seqA", 1'b1, 32'hA000_0000, 32'd0, 1'b0);
        chk("seqA.addr", rom_addr, 32'd1);
        step();
        chk_out("seqB", 1'b1, 32'hA000_0001, 32'd1, 1'b0);

        // Back-pressure holds B
        ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            chk_out("stallB", 1'b1, 32'hA000_0001, 32'd1, 1'b0);
            chk("stallB.addr", rom_addr, 32'd2);
        end
        ready = 1'b1;
        step();
        chk_out("seqC", 1'b1, 32'hA000_0002, 32'd2, 1'b0);
        step();
        chk_out("seqD", 1'b1, 32'hA000_0003, 32'd3, 1'b0);

        // Redirect to 0x47 -> word 7 with one bubble
        redirect = 1'b1; redirect_pc = 32'h0000_0047;
        step();
        redirect = 1'b0;
        chk("redir.bubble", {31'd0, valid}, 32'd0);
        chk("redir.addr", rom_addr, 32'd7);
        step();
        chk_out("redir.t7", 1'b1, 32'hA000_0007, 32'd7, 1'b0);
        step();
        chk_out("redir.t8", 1'b1, 32'hA000_0008, 32'd8, 1'b0);

        // Wrap 62, 63, 0, 1
        redirect = 1'b1; redirect_pc = 32'd62;
        step();
        redirect = 1'b0;
        chk("wrap.bubble", {31'd0, valid}, 32'd0);
        step();
        chk_out("wrap62", 1'b1, 32'hA000_003E, 32'd62, 1'b0);
        step();
        chk_out("wrap63", 1'b1, 32'hA000_003F, 32'd63, 1'b0);
        chk("wrap.addr", rom_addr, 32'd0);
        step();
        chk_out("wrap0", 1'b1, 32'hA000_0000, 32'd0, 1'b0);
        step();
        chk_out("wrap1", 1'b1, 32'hA000_0001, 32'd1, 1'b0);

        // start_i in RUN is ignored
        start = 1'b1;
        step();
        start = 1'b0;
        chk("run.start.pc", pc_out, 32'd2);

        // HALT at word 2
        rom[2] = 32'hFC00_0000;
        redirect = 1'b1; redirect_pc = 32'd0;
        step();
        redirect = 1'b0;
        step();
        chk("halt.p0", pc_out, 32'd0);
        step();
        chk("halt.p1", pc_out, 32'd1);
        step();
        chk_out("halt.inst", 1'b1, 32'hFC00_0000, 32'd2, 1'b0);
        step();
        chk_out("halted", 1'b0, 32'hFC00_0000, 32'd2, 1'b1);
        chk("halted.addr", rom_addr, 32'd3);
        step(); step();
        chk_out("halted.hold", 1'b0, 32'hFC00_0000, 32'd2, 1'b1);
        redirect = 1'b1; redirect_pc = 32'd5;
        step();
        redirect = 1'b0;
        chk("halted.redir.addr", rom_addr, 32'd3);
        chk("halted.redir.h", {31'd0, halted}, 32'd1);

        // Restart from HALTED
        start = 1'b1;
        step();
        start = 1'b0;
        chk("restart.halted", {31'd0, halted}, 32'd0);
        chk("restart.addr", rom_addr, 32'd0);
        step();
        chk_out("restart.p0", 1'b1, 32'hA000_0000, 32'd0, 1'b0);
        step();
        step();
        chk_out("restart.halt", 1'b1, 32'hFC00_0000, 32'd2, 1'b0);

        // Redirect coincident with HALT transfer: no halt
        redirect = 1'b1; redirect_pc = 32'd10;
        step();
        redirect = 1'b0;
        chk("rh.halted", {31'd0, halted}, 32'd0);
        chk("rh.valid", {31'd0, valid}, 32'd0);
        chk("rh.addr", rom_addr, 32'd10);
        step();
        chk_out("rh.t10", 1'b1, 32'hA000_000A, 32'd10, 1'b0);

        // Mid-run reset while valid && !ready
        ready = 1'b0;
        step();
        chk_out("mr.hold", 1'b1, 32'hA000_000A, 32'd10, 1'b0);
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        chk_out("mr.reset", 1'b0, 32'd0, 32'd0, 1'b0);
        chk("mr.addr", rom_addr, 32'd0);
        redirect = 1'b1; redirect_pc = 32'd20; ready = 1'b1;
        step();
        redirect = 1'b0;
        chk("mr.idle.valid", {31'd0, valid}, 32'd0);
        chk("mr.idle.addr", rom_addr, 32'd0);
        step();
        chk("mr.idle2.valid", {31'd0, valid}, 32'd0);
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk_out("mr.start", 1'b1, 32'hA000_0000, 32'd0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
